// File: rtl/per_master_rr_arbiter.sv
// Round-robin arbiter sharing one peripheral-interconnect master port among NB_MASTERS
// requesters, one outstanding transaction, response steered back to the granted owner.
module per_master_rr_arbiter #(
  parameter int NB_MASTERS     = 2,
  parameter int PER_ADDR_WIDTH = 32,
  localparam int IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NB_MASTERS-1:0]                slv_req_i,
  input  logic [NB_MASTERS*PER_ADDR_WIDTH-1:0] slv_add_i,
  input  logic [NB_MASTERS-1:0]                slv_we_i,
  input  logic [NB_MASTERS*32-1:0]             slv_wdata_i,
  input  logic [NB_MASTERS*4-1:0]              slv_be_i,
  output logic [NB_MASTERS-1:0]                slv_gnt_o,
  output logic [NB_MASTERS-1:0]                slv_r_valid_o,
  output logic [31:0]                          slv_r_rdata_o,
  output logic                                 per_master_req_o,
  output logic [PER_ADDR_WIDTH-1:0]            per_master_add_o,
  output logic                                 per_master_we_o,
  output logic [31:0]                          per_master_wdata_o,
  output logic [3:0]                           per_master_be_o,
  input  logic                                 per_master_gnt_i,
  input  logic                                 per_master_r_valid_i,
  input  logic [31:0]                          per_master_r_rdata_i
);

  typedef enum logic {IDLE, WAIT_RESP} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, winner;
  logic             any_req;

  logic [NB_MASTERS-1:0][PER_ADDR_WIDTH-1:0] add_a;
  logic [NB_MASTERS-1:0][31:0]               wdata_a;
  logic [NB_MASTERS-1:0][3:0]                be_a;

  assign add_a   = slv_add_i;
  assign wdata_a = slv_wdata_i;
  assign be_a    = slv_be_i;

  assign slv_r_rdata_o = per_master_r_rdata_i;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NB_MASTERS) s -= NB_MASTERS;
    return IDX_W'(s);
  endfunction

  // Scan from the far end back to rr_ptr so the closest requester is written last and wins.
  always_comb begin
    winner  = rr_ptr_q;
    any_req = |slv_req_i;
    for (int k = NB_MASTERS-1; k >= 0; k--) begin
      if (slv_req_i[wrap_add(rr_ptr_q, k)]) winner = wrap_add(rr_ptr_q, k);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    rr_ptr_d           = rr_ptr_q;
    owner_d            = owner_q;
    per_master_req_o   = 1'b0;
    per_master_add_o   = '0;
    per_master_we_o    = 1'b0;
    per_master_wdata_o = '0;
    per_master_be_o    = '0;
    slv_gnt_o          = '0;
    slv_r_valid_o      = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          per_master_req_o   = 1'b1;
          per_master_add_o   = add_a[winner];
          per_master_we_o    = slv_we_i[winner];
          per_master_wdata_o = wdata_a[winner];
          per_master_be_o    = be_a[winner];
          slv_gnt_o[winner]  = per_master_gnt_i;
          if (per_master_gnt_i) begin
            owner_d  = winner;
            rr_ptr_d = (winner == IDX_W'(NB_MASTERS-1)) ? '0 : winner + 1'b1;
            state_d  = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (per_master_r_valid_i) begin
          slv_r_valid_o[owner_q] = 1'b1;
          state_d                = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are combinational, so hold them quiet while reset is asserted.
    if (!rst_ni) begin
      per_master_req_o   = 1'b0;
      per_master_add_o   = '0;
      per_master_we_o    = 1'b0;
      per_master_wdata_o = '0;
      per_master_be_o    = '0;
      slv_gnt_o          = '0;
      slv_r_valid_o      = '0;
    end
  end

endmodule

// File: tb/tb_per_master_rr_arbiter.sv
// Scoreboard bench: a transaction-level model predicts each cycle's outputs and the grant
// order; a monitor on the falling edge pops and compares.
module tb_per_master_rr_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [N-1:0]          req, we;
  logic [N-1:0][AW-1:0]  add_a;
  logic [N-1:0][31:0]    wd_a;
  logic [N-1:0][3:0]     be_a;
  logic                  gnt, rvalid;
  logic [31:0]           rdata;

  logic [N-1:0]  slv_gnt, slv_rv;
  logic [31:0]   slv_rdata;
  logic          m_req, m_we;
  logic [AW-1:0] m_add;
  logic [31:0]   m_wdata;
  logic [3:0]    m_be;

  per_master_rr_arbiter #(.NB_MASTERS(N), .PER_ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(req), .slv_add_i(add_a), .slv_we_i(we), .slv_wdata_i(wd_a), .slv_be_i(be_a),
    .slv_gnt_o(slv_gnt), .slv_r_valid_o(slv_rv), .slv_r_rdata_o(slv_rdata),
    .per_master_req_o(m_req), .per_master_add_o(m_add), .per_master_we_o(m_we),
    .per_master_wdata_o(m_wdata), .per_master_be_o(m_be),
    .per_master_gnt_i(gnt), .per_master_r_valid_i(rvalid), .per_master_r_rdata_i(rdata)
  );

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [N-1:0]  rv;
    logic [31:0]   rdata;
    logic          req;
    logic [AW-1:0] add;
    logic          we;
    logic [31:0]   wdata;
    logic [3:0]    be;
  } obs_t;

  obs_t exp_q[$];
  int   gnt_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: busy flag, next-to-serve pointer, current owner.
  bit m_busy = 0;
  int m_ptr  = 0;
  int m_own  = 0;
  bit fix1   = 0;
  bit fix_rd = 0;

  task automatic cyc(input bit r, input logic [N-1:0] rq, input bit g, input bit rv);
    obs_t e;
    int   w;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      add_a[i] = $urandom; wd_a[i] = $urandom; be_a[i] = 4'($urandom); we[i] = 1'($urandom);
    end
    rdata = $urandom;
    if (fix1) begin add_a[1] = 32'h1A10_0004; we[1] = 1'b0; end
    if (fix_rd) rdata = 32'hDEAD_BEEF;
    rst_n = r; req = rq; gnt = g; rvalid = rv;
    e = '0;
    e.rdata = rdata;
    if (!r) begin
      m_busy = 0; m_ptr = 0; m_own = 0;
    end else if (!m_busy) begin
      w = -1;
      for (int off = 0; off < N; off++)
        if (w < 0 && rq[(m_ptr + off) % N]) w = (m_ptr + off) % N;
      if (w >= 0) begin
        e.req = 1'b1; e.add = add_a[w]; e.we = we[w]; e.wdata = wd_a[w]; e.be = be_a[w];
        e.gnt[w] = g;
        if (g) begin
          gnt_q.push_back(w);
          m_own = w; m_ptr = (w + 1) % N; m_busy = 1;
        end
      end
    end else if (rv) begin
      e.rv[m_own] = 1'b1;
      m_busy = 0;
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    obs_t         act, e;
    int           w;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      act.gnt = slv_gnt; act.rv = slv_rv; act.rdata = slv_rdata; act.req = m_req;
      act.add = m_add; act.we = m_we; act.wdata = m_wdata; act.be = m_be;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (act !== e) begin
          n_err++;
          $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, act, e);
        end
      end
      if (act.gnt != '0) begin
        n_cmp++;
        if (gnt_q.size() == 0) begin
          n_err++;
          $display("FAIL grant_order t=%0t: got gnt %b expected no grant", $time, act.gnt);
        end else begin
          w = gnt_q.pop_front();
          oh = '0; oh[w] = 1'b1;
          if (act.gnt !== oh) begin
            n_err++;
            $display("FAIL grant_order t=%0t: got gnt %b expected %b", $time, act.gnt, oh);
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0] rq;
    rst_n = 1'b0; req = '1; gnt = 1'b1; rvalid = 1'b1; rdata = '0;
    add_a = '0; wd_a = '0; be_a = '0; we = '0;
    // Reset held with every requester asserting: outputs quiet, then requester 0 first.
    repeat (3) cyc(0, 3'b111, 1, 1);
    // Full rotation 0,1,2,0 with the response two cycles after each grant.
    repeat (4) begin
      cyc(1, 3'b111, 1, 0);
      cyc(1, 3'b111, 0, 0);
      cyc(1, 3'b111, 0, 1);
    end
    // Requester 1 read stalled by the interconnect for three cycles.
    fix1 = 1;
    repeat (3) cyc(1, 3'b010, 0, 0);
    cyc(1, 3'b010, 1, 0);
    fix_rd = 1;
    cyc(1, 3'b000, 0, 1);
    fix1 = 0; fix_rd = 0;
    // New request arriving while a response is still pending.
    cyc(1, 3'b010, 1, 0);
    cyc(1, 3'b011, 1, 0);
    cyc(1, 3'b011, 1, 0);
    cyc(1, 3'b001, 1, 1);
    cyc(1, 3'b001, 1, 0);
    cyc(1, 3'b000, 0, 1);
    // Spurious response in idle, and a response coincident with the grant.
    cyc(1, 3'b000, 0, 1);
    cyc(1, 3'b100, 1, 1);
    cyc(1, 3'b000, 0, 1);
    // Withdrawal before grant: nothing latched.
    cyc(1, 3'b110, 0, 0);
    cyc(1, 3'b001, 1, 0);
    cyc(1, 3'b000, 0, 1);
    // Reset while waiting for a response; the late response is dropped.
    cyc(1, 3'b100, 1, 0);
    cyc(0, 3'b100, 1, 0);
    cyc(1, 3'b000, 0, 1);
    cyc(1, 3'b111, 1, 0);
    cyc(1, 3'b000, 0, 1);
    // Random traffic with occasional resets.
    repeat (3000) begin
      rq = N'($urandom_range(0, (1 << N) - 1));
      cyc($urandom_range(0, 99) != 0, rq, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (exp_q.size() != 0 || gnt_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d entries left, expected 0/0", exp_q.size(), gnt_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
